uart_tx_ctrl: RTL
=================

Name: uart_tx_ctrl

Overview:
UART transmit sequencer that owns the 8-bit parallel-in/serial-out shift register in the TX path. It accepts a byte over a valid/ready handshake and captures it. It then drives the shift register's load_data/shift controls and times start, data, optional parity and stop bits with an internal baud counter. It outputs the serial line txd, framing databit from the shift register LSB.

Parameters:
CLKS_PER_BIT, 16, clk cycles per UART bit; legal >= 2
STOP_BITS, 1, number of stop bits; legal 1 or 2
PARITY_ODD, 0, 1 = odd parity, 0 = even; used only when UART_TX_PARITY_EN is defined

Ports:
clk  input  1  system clock, all logic on posedge
rst  input  1  synchronous, active-high reset
tx_start  input  1  byte-valid request from host
tx_datain  input  8  byte to send, sampled on accept
tx_ready  output  1  high only in IDLE; accept = tx_start && tx_ready at posedge
piso_data  output  8  captured byte, drives shift-register parallel input
load_data  output  1  one-cycle load strobe to shift register
shift  output  1  one-cycle shift strobe to shift register (LSB-first)
databit  input  1  shift-register LSB
txd  output  1  serial line, idle high
busy  output  1  high in every state except IDLE
tx_done  output  1  one-cycle pulse in the last cycle of the final stop bit

Behaviour:
- Reset (rst high at posedge) from any state, including mid-frame:
  - Next cycle: state IDLE; baud/bit counters 0; piso_data 8'h00.
  - txd=1, tx_ready=1, busy=0, load_data=0, shift=0, tx_done=0.
  - A frame in progress is abandoned with no tx_done.
- All outputs are registered or decoded from registered state only; no combinational path from tx_start or tx_datain to any output.
- States: IDLE -> LOAD -> START -> DATA -> [PARITY] -> STOP -> IDLE.
- IDLE:
  - txd=1, tx_ready=1.
  - On accept: piso_data <= tx_datain; next state LOAD.
  - tx_start while not in IDLE is ignored; the host must hold it until accepted.
- LOAD (exactly 1 cycle):
  - load_data=1, txd=1.
  - Baud counter cleared; next state START.
- START:
  - txd=0 for CLKS_PER_BIT cycles.
  - Baud counter counts 0..CLKS_PER_BIT-1 and wraps to 0 on the last cycle, then next state DATA with bit index 0.
- DATA:
  - txd=databit, 8 bit periods of CLKS_PER_BIT cycles each.
  - shift=1 in the last cycle of every data bit period, including bit 7.
  - Bit index 0..7 increments at each period end; after index 7, next state PARITY (if compiled) else STOP.
  - The shift register therefore presents D0 first, then D1..D7.
- STOP:
  - txd=1 for STOP_BITS*CLKS_PER_BIT cycles.
  - tx_done=1 in the final cycle; next state IDLE.
- Back-to-back frames: tx_start held high gives accept in the first IDLE cycle after STOP.
  - Accept-to-accept period = 2 + (10 + STOP_BITS - 1 + P)*CLKS_PER_BIT cycles, where P = 1 with parity else 0.
- Simultaneous rst and tx_start: reset wins, no accept.
- Counter width: $clog2(CLKS_PER_BIT*STOP_BITS) bits minimum; no overflow at boundary values.

Optional Feature:
- Macro: UART_TX_PARITY_EN
- Defined:
  - PARITY state is inserted after DATA for one bit period.
  - txd = ^piso_data when PARITY_ODD=0; txd = ~^piso_data when PARITY_ODD=1.
  - No shift strobe during PARITY.
- Undefined:
  - No PARITY state; DATA goes directly to STOP.
  - PARITY_ODD is ignored; frame is 8N1/8N2.

Test Plan:
- Reset then idle 20 cycles -> txd=1, tx_ready=1, busy=0, load_data=shift=tx_done=0 throughout.
- CLKS_PER_BIT=4, STOP_BITS=1, no parity; send 8'hA5 -> load_data 1 cycle after accept.
  - txd: 4 cycles 0, then 1,0,1,0,0,1,0,1 at 4 cycles each, then 4 cycles 1.
  - shift pulses every 4th cycle, 8 total.
  - tx_done pulse 41 cycles after accept edge.
- Same setup, tx_start held high with 8'h00 then 8'hFF -> accepts exactly 42 cycles apart.
  - Second frame data bits all 1.
  - tx_start ignored while busy=1.
- Assert rst during DATA bit 3 -> next cycle IDLE, txd=1, no tx_done.
  - Next send of 8'h3C transmits correctly.
- STOP_BITS=2, CLKS_PER_BIT=3, send 8'h81 -> stop high for 6 cycles; tx_done on the 6th.
- UART_TX_PARITY_EN, PARITY_ODD=0, CLKS_PER_BIT=4, send 8'h07 -> parity period txd=1.
  - With PARITY_ODD=1 -> txd=0.
  - Frame is 1 bit period longer.

Source files
------------

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: UART TX sequencer driving an external PISO; parity stage enabled by UART_TX_PARITY_EN
module uart_tx_ctrl #(
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_start,
  input  logic [7:0] tx_datain,
  output logic       tx_ready,
  output logic [7:0] piso_data,
  output logic       load_data,
  output logic       shift,
  input  logic       databit,
  output logic       txd,
  output logic       busy,
  output logic       tx_done
);
  localparam int CW = $clog2(CLKS_PER_BIT * STOP_BITS);
  localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] STOP_END = CW'(CLKS_PER_BIT * STOP_BITS - 1);
  typedef enum logic [2:0] {IDLE, LOAD, START, DATA, PARITY, STOP} state_t;
  state_t state, next;
  logic [CW-1:0] cnt;
  logic [2:0] bit_idx;
  logic bit_end, stop_end, wrap, par_bit;
  assign bit_end  = cnt == BIT_END;
  assign stop_end = cnt == STOP_END;
  assign wrap     = (state == STOP) ? stop_end : bit_end;
  assign par_bit  = (^piso_data) ^ (PARITY_ODD != 0);
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      piso_data <= '0;
    end else begin
      state     <= next;
      cnt       <= (state == IDLE || state == LOAD || wrap) ? '0 : cnt + 1'b1;
      bit_idx   <= (state == DATA) ? bit_idx + {2'b00, bit_end} : '0;
      piso_data <= (state == IDLE && tx_start) ? tx_datain : piso_data;
    end
  end
  always_comb begin
    next = state;
    unique case (state)
      IDLE:   next = tx_start ? LOAD : IDLE;
      LOAD:   next = START;
      START:  next = bit_end ? DATA : START;
`ifdef UART_TX_PARITY_EN
      DATA:   next = (bit_end && bit_idx == 3'd7) ? PARITY : DATA;
`else
      DATA:   next = (bit_end && bit_idx == 3'd7) ? STOP : DATA;
`endif
      PARITY: next = bit_end ? STOP : PARITY;
      STOP:   next = stop_end ? IDLE : STOP;
      default: next = IDLE;
    endcase
  end
  assign tx_ready  = state == IDLE;
  assign busy      = state != IDLE;
  assign load_data = state == LOAD;
  assign shift     = state == DATA && bit_end;
  assign tx_done   = state == STOP && stop_end;
  assign txd       = (state == START) ? 1'b0 :
                     (state == DATA)  ? databit :
                     (state == PARITY) ? par_bit : 1'b1;
endmodule
